// File: rtl/vpe_gather_pkg.sv
// Shared sizing constants for the VPE result gather block and its per-lane slots.
// Lane count must be a power of two so the drain pointer wraps naturally.
package vpe_gather_pkg;

  localparam int NUM_VPE = 8;
  localparam int DATA_W  = 256;
  localparam int PTR_W   = $clog2(NUM_VPE);
  localparam int CNT_W   = 16;

endpackage : vpe_gather_pkg

// File: rtl/vpe_result_slot.sv
// One lane's holding register and occupied bit; writes to a full slot are dropped.
// Sticky overflow detection exists only when VPE_GATHER_OVF_CHECK_EN is defined.
module vpe_result_slot #(
  parameter int DATA_W = vpe_gather_pkg::DATA_W
) (
  input  logic              clk_octo,
  input  logic              rst_octo,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic              wrValid_i,
  input  logic              drain_i,
  output logic [DATA_W-1:0] data_o,
  output logic              occupied_o,
  output logic              overflow_o
);
  import vpe_gather_pkg::*;

  logic [DATA_W-1:0] data_q, data_d;
  logic              occupied_q, occupied_d;

  // Drain only happens on an occupied slot and capture only on an empty one, so
  // they never coincide; a slot drained this cycle refills no earlier than next.
  always_comb begin
    data_d     = data_q;
    occupied_d = occupied_q;
    if (clear_i) begin
      occupied_d = 1'b0;
    end else if (drain_i) begin
      occupied_d = 1'b0;
    end else if (wrValid_i && !occupied_q) begin
      occupied_d = 1'b1;
      data_d     = wrData_i;
    end
  end

  always_ff @(posedge clk_octo or posedge rst_octo) begin
    if (rst_octo) begin
      data_q     <= '0;
      occupied_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      occupied_q <= occupied_d;
    end
  end

  assign data_o     = data_q;
  assign occupied_o = occupied_q;

`ifdef VPE_GATHER_OVF_CHECK_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (clear_i) begin
      overflow_d = 1'b0;
    end else if (wrValid_i && occupied_q) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_octo or posedge rst_octo) begin
    if (rst_octo) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

endmodule : vpe_result_slot

// File: rtl/vpe_result_gather.sv
// Gathers per-lane VPE results into one FIFO write stream in strict lane order.
// Optional sticky overflow detection: define VPE_GATHER_OVF_CHECK_EN.
module vpe_result_gather #(
  parameter int NUM_VPE = vpe_gather_pkg::NUM_VPE,
  parameter int DATA_W  = vpe_gather_pkg::DATA_W
) (
  input  logic                             clk_octo,
  input  logic                             rst_octo,
  input  logic                             i_clear,
  input  logic [NUM_VPE*DATA_W-1:0]        i_vpe_result,
  input  logic [NUM_VPE-1:0]               i_vpe_valid,
  output logic [NUM_VPE-1:0]               o_vpe_ready,
  input  logic                             i_fifo_full,
  output logic [DATA_W-1:0]                o_result,
  output logic                             o_result_valid,
  output logic [vpe_gather_pkg::CNT_W-1:0] o_word_cnt,
  output logic                             o_busy,
  output logic                             o_overflow
);
  import vpe_gather_pkg::*;

  localparam int LANE_PTR_W = $clog2(NUM_VPE);

  logic [DATA_W-1:0]     slotData [NUM_VPE];
  logic [NUM_VPE-1:0]    slotOccupied;
  logic [NUM_VPE-1:0]    slotOverflow;
  logic [NUM_VPE-1:0]    slotDrain;

  logic [LANE_PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  resultValid_q, resultValid_d;
  logic [CNT_W-1:0]      wordCnt_q, wordCnt_d;
  logic                  drainEn;

  for (genvar k = 0; k < NUM_VPE; k++) begin : gSlot
    assign slotDrain[k] = drainEn && (rdPtr_q == LANE_PTR_W'(k));

    vpe_result_slot #(
      .DATA_W (DATA_W)
    ) uSlot (
      .clk_octo   (clk_octo),
      .rst_octo   (rst_octo),
      .clear_i    (i_clear),
      .wrData_i   (i_vpe_result[k*DATA_W +: DATA_W]),
      .wrValid_i  (i_vpe_valid[k]),
      .drain_i    (slotDrain[k]),
      .data_o     (slotData[k]),
      .occupied_o (slotOccupied[k]),
      .overflow_o (slotOverflow[k])
    );
  end

  // The pointer never skips an empty lane, so output order always matches the
  // distribution order even when later lanes finish first.
  assign drainEn = !i_clear && slotOccupied[rdPtr_q] && !i_fifo_full;

  always_comb begin
    rdPtr_d       = rdPtr_q;
    result_d      = result_q;
    resultValid_d = 1'b0;
    wordCnt_d     = wordCnt_q;
    if (i_clear) begin
      rdPtr_d   = '0;
      wordCnt_d = '0;
    end else if (drainEn) begin
      rdPtr_d       = rdPtr_q + 1'b1;
      result_d      = slotData[rdPtr_q];
      resultValid_d = 1'b1;
      wordCnt_d     = wordCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_octo or posedge rst_octo) begin
    if (rst_octo) begin
      rdPtr_q       <= '0;
      result_q      <= '0;
      resultValid_q <= 1'b0;
      wordCnt_q     <= '0;
    end else begin
      rdPtr_q       <= rdPtr_d;
      result_q      <= result_d;
      resultValid_q <= resultValid_d;
      wordCnt_q     <= wordCnt_d;
    end
  end

  assign o_vpe_ready    = ~slotOccupied;
  assign o_busy         = |slotOccupied;
  assign o_overflow     = |slotOverflow;
  assign o_result       = result_q;
  assign o_result_valid = resultValid_q;
  assign o_word_cnt     = wordCnt_q;

endmodule : vpe_result_gather

// File: tb/tb_vpe_result_gather.sv
// Directed self-checking bench for vpe_result_gather: ordering, backpressure,
// wrap, overflow (follows VPE_GATHER_OVF_CHECK_EN) and mid-run reset.
module tb_vpe_result_gather;

  localparam int NUM_VPE = 8;
  localparam int DATA_W  = 256;

  logic                      clk_octo = 1'b0;
  logic                      rst_octo;
  logic                      i_clear;
  logic [NUM_VPE*DATA_W-1:0] i_vpe_result;
  logic [NUM_VPE-1:0]        i_vpe_valid;
  logic [NUM_VPE-1:0]        o_vpe_ready;
  logic                      i_fifo_full;
  logic [DATA_W-1:0]         o_result;
  logic                      o_result_valid;
  logic [15:0]               o_word_cnt;
  logic                      o_busy;
  logic                      o_overflow;

  int totalChecks = 0;
  int badChecks   = 0;
  int cycleCount  = 0;
  logic [DATA_W-1:0] gotWords [$];
  int                gotCycles [$];

  vpe_result_gather #(
    .NUM_VPE (NUM_VPE),
    .DATA_W  (DATA_W)
  ) dut (
    .clk_octo       (clk_octo),
    .rst_octo       (rst_octo),
    .i_clear        (i_clear),
    .i_vpe_result   (i_vpe_result),
    .i_vpe_valid    (i_vpe_valid),
    .o_vpe_ready    (o_vpe_ready),
    .i_fifo_full    (i_fifo_full),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_word_cnt     (o_word_cnt),
    .o_busy         (o_busy),
    .o_overflow     (o_overflow)
  );

  initial forever #5 clk_octo = ~clk_octo;

  always @(posedge clk_octo) cycleCount <= cycleCount + 1;

  // Record every emitted word mid-cycle, well away from the active edge.
  always @(negedge clk_octo) begin
    if (!rst_octo && o_result_valid) begin
      gotWords.push_back(o_result);
      gotCycles.push_back(cycleCount);
    end
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of lane strobes; lane k carries base+k.
  task automatic applyStimulus(input logic [NUM_VPE-1:0] valid, input int base);
    for (int k = 0; k < NUM_VPE; k++)
      i_vpe_result[k*DATA_W +: DATA_W] = DATA_W'(base + k);
    i_vpe_valid = valid;
    @(posedge clk_octo);
    #1;
    i_vpe_valid = '0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_octo);
      #1;
    end
  endtask

  task automatic applyClear();
    i_clear = 1'b1;
    idleCycles(1);
    i_clear = 1'b0;
    gotWords.delete();
    gotCycles.delete();
  endtask

  function automatic logic [DATA_W-1:0] wordAt(input int i);
    if (i < gotWords.size()) return gotWords[i];
    return '1;
  endfunction

  function automatic int cycleGap(input int i);
    if (i < gotCycles.size()) return gotCycles[i] - gotCycles[0];
    return -1;
  endfunction

  task automatic checkStream(input string tag, input int n, input int base, input int stride);
    checkOutput({tag, "_count"}, DATA_W'(gotWords.size()), DATA_W'(n));
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_word%0d", tag, i), wordAt(i), DATA_W'(base + i + (i / 8) * stride));
      checkOutput($sformatf("%s_gap%0d", tag, i), DATA_W'(cycleGap(i)), DATA_W'(i));
    end
  endtask

  initial begin
    rst_octo     = 1'b1;
    i_clear      = 1'b0;
    i_vpe_result = '0;
    i_vpe_valid  = '0;
    i_fifo_full  = 1'b0;
    idleCycles(3);
    rst_octo = 1'b0;
    idleCycles(1);

    checkOutput("rst_ready", DATA_W'(o_vpe_ready), DATA_W'(8'hFF));
    checkOutput("rst_result", o_result, '0);
    checkOutput("rst_valid", DATA_W'(o_result_valid), '0);
    checkOutput("rst_cnt", DATA_W'(o_word_cnt), '0);
    checkOutput("rst_busy", DATA_W'(o_busy), '0);
    checkOutput("rst_ovf", DATA_W'(o_overflow), '0);

    $display("[TB] in-order gather");
    for (int k = 0; k < NUM_VPE; k++) applyStimulus(NUM_VPE'(1 << k), 'h100);
    idleCycles(4);
    checkStream("inorder", 8, 'h100, 0);
    checkOutput("inorder_cnt", DATA_W'(o_word_cnt), DATA_W'(8));
    checkOutput("inorder_busy", DATA_W'(o_busy), '0);

    $display("[TB] out-of-order arrival");
    applyClear();
    checkOutput("clear_cnt", DATA_W'(o_word_cnt), '0);
    checkOutput("clear_result_hold", o_result, DATA_W'('h107));
    applyStimulus(8'h08, 'h300);
    idleCycles(1);
    checkOutput("ooo_ready", DATA_W'(o_vpe_ready), DATA_W'(8'hF7));
    checkOutput("ooo_busy", DATA_W'(o_busy), DATA_W'(1));
    checkOutput("ooo_none_yet", DATA_W'(gotWords.size()), '0);
    applyStimulus(8'h01, 'h300);
    applyStimulus(8'h02, 'h300);
    applyStimulus(8'h04, 'h300);
    idleCycles(4);
    checkOutput("ooo_count", DATA_W'(gotWords.size()), DATA_W'(4));
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("ooo_word%0d", i), wordAt(i), DATA_W'('h300 + i));
    checkOutput("ooo_cnt", DATA_W'(o_word_cnt), DATA_W'(4));

    $display("[TB] backpressure");
    applyClear();
    i_fifo_full = 1'b1;
    applyStimulus(8'hFF, 'h500);
    idleCycles(5);
    checkOutput("bp_none", DATA_W'(gotWords.size()), '0);
    checkOutput("bp_ready", DATA_W'(o_vpe_ready), '0);
    checkOutput("bp_busy", DATA_W'(o_busy), DATA_W'(1));
    checkOutput("bp_valid", DATA_W'(o_result_valid), '0);
    checkOutput("bp_hold", o_result, DATA_W'('h303));
    i_fifo_full = 1'b0;
    idleCycles(10);
    checkStream("bp", 8, 'h500, 0);
    checkOutput("bp_cnt", DATA_W'(o_word_cnt), DATA_W'(8));

    $display("[TB] pointer wrap");
    applyClear();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NUM_VPE; k++) applyStimulus(NUM_VPE'(1 << k), 'h600 + r * 'h10);
    idleCycles(4);
    checkStream("wrap", 24, 'h600, 'h8);
    checkOutput("wrap_cnt", DATA_W'(o_word_cnt), DATA_W'(24));

    $display("[TB] overflow");
    applyClear();
    i_fifo_full = 1'b1;
    applyStimulus(8'h04, 'h700);
    applyStimulus(8'h04, 'h780);
`ifdef VPE_GATHER_OVF_CHECK_EN
    checkOutput("ovf_set", DATA_W'(o_overflow), DATA_W'(1));
`else
    checkOutput("ovf_tied", DATA_W'(o_overflow), '0);
`endif
    applyStimulus(8'h03, 'h700);
    i_fifo_full = 1'b0;
    idleCycles(6);
    checkOutput("ovf_count", DATA_W'(gotWords.size()), DATA_W'(3));
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("ovf_word%0d", i), wordAt(i), DATA_W'('h700 + i));
    applyClear();
    checkOutput("ovf_cleared", DATA_W'(o_overflow), '0);
    checkOutput("ovf_cnt_cleared", DATA_W'(o_word_cnt), '0);

    $display("[TB] reset mid-run");
    i_fifo_full = 1'b1;
    applyStimulus(8'h07, 'h900);
    checkOutput("midrst_busy", DATA_W'(o_busy), DATA_W'(1));
    rst_octo = 1'b1;
    idleCycles(2);
    rst_octo    = 1'b0;
    i_fifo_full = 1'b0;
    gotWords.delete();
    gotCycles.delete();
    idleCycles(10);
    checkOutput("midrst_none", DATA_W'(gotWords.size()), '0);
    checkOutput("midrst_ready", DATA_W'(o_vpe_ready), DATA_W'(8'hFF));
    checkOutput("midrst_result", o_result, '0);
    checkOutput("midrst_cnt", DATA_W'(o_word_cnt), '0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule : tb_vpe_result_gather

// File: doc/vpe_result_gather.md
VPE_RESULT_GATHER -- requirements
Module: vpe_result_gather

Interface
REQ-001 The block SHALL have parameter NUM_VPE, default 8, the number of VPE lanes; its value SHALL be a power of two.
REQ-002 The block SHALL have parameter DATA_W, default 256, the result width per lane.
REQ-003 The block SHALL have port clk_octo  in  1  lane-side clock; reset rst_octo, asynchronous, active-high; clock clk_octo.
REQ-004 The block SHALL have port rst_octo  in  1  asynchronous active-high reset.
REQ-005 The block SHALL have port i_clear  in  1  synchronous clear of pointer, slots and status.
REQ-006 The block SHALL have port i_vpe_result  in  NUM_VPE*DATA_W  per-lane results; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-007 The block SHALL have port i_vpe_valid  in  NUM_VPE  per-lane result strobe.
REQ-008 The block SHALL have port o_vpe_ready  out  NUM_VPE  per-lane slot-empty indication.
REQ-009 The block SHALL have port i_fifo_full  in  1  result FIFO full, from the downstream write port.
REQ-010 The block SHALL have port o_result  out  DATA_W  FIFO write data.
REQ-011 The block SHALL have port o_result_valid  out  1  FIFO write enable, single-cycle pulse per word.
REQ-012 The block SHALL have port o_word_cnt  out  16  count of words emitted since reset or clear.
REQ-013 The block SHALL have port o_busy  out  1  asserted while any slot is occupied.
REQ-014 The block SHALL have port o_overflow  out  1  sticky overflow flag.

Function
REQ-015 Each lane SHALL own one holding slot of DATA_W bits plus an occupied bit.
REQ-016 o_vpe_ready[k] SHALL equal the inverse of occupied[k] as registered at the current cycle.
REQ-017 When i_vpe_valid[k] and o_vpe_ready[k] are both high, slot k SHALL capture the lane data and be occupied at the next edge.
REQ-018 A 3-bit (log2 NUM_VPE) read pointer SHALL select the lane to drain; lanes SHALL drain in strict order 0,1,...,NUM_VPE-1,0, matching the distribution order.
REQ-019 Drain SHALL occur when occupied[rd_ptr]=1 and i_fifo_full=0 in the same cycle.
REQ-020 On drain, the block SHALL register o_result with the slot data, pulse o_result_valid for one cycle, clear occupied[rd_ptr], and advance rd_ptr.
REQ-021 The drain latency SHALL be one cycle from the capture edge to o_result_valid at the earliest.
REQ-022 rd_ptr SHALL wrap from NUM_VPE-1 to 0 without a gap cycle.
REQ-023 The block SHALL NOT skip a lane: if occupied[rd_ptr]=0, the pointer SHALL hold even when other slots are occupied.
REQ-024 While i_fifo_full=1, no drain SHALL occur; o_result SHALL hold its value and o_result_valid SHALL be 0.
REQ-025 When a lane drains in a cycle, its slot SHALL accept new data no earlier than the following cycle; same-cycle refill is not supported.
REQ-026 o_word_cnt SHALL increment by 1 on each drain and wrap modulo 2^16.
REQ-027 o_busy SHALL be the OR of all occupied bits.
REQ-028 i_clear SHALL take priority over capture and drain: slots are emptied, rd_ptr=0, o_word_cnt=0, o_overflow=0, and o_result_valid=0 at the next edge; o_result SHALL retain its value.

Reset
REQ-029 On rst_octo, all slots SHALL be empty, rd_ptr=0, o_result=0, o_result_valid=0, o_word_cnt=0, and o_overflow=0.
REQ-030 On rst_octo, o_vpe_ready SHALL be all-ones.
REQ-031 Reset asserted mid-transfer SHALL discard slot contents; no partial word SHALL be emitted after release.

Configuration
REQ-032 With VPE_GATHER_OVF_CHECK_EN defined, i_vpe_valid[k] while occupied[k]=1 SHALL drop the data and set o_overflow, which stays set until reset or i_clear.
REQ-033 Without VPE_GATHER_OVF_CHECK_EN, o_overflow SHALL be tied 0 and the detection logic SHALL be absent; a write to an occupied slot SHALL still be ignored.

Structure
REQ-034 A shared package vpe_gather_pkg SHALL hold NUM_VPE, DATA_W, the pointer width PTR_W=$clog2(NUM_VPE), and the word counter width CNT_W=16.
REQ-035 One sub-module, vpe_result_slot (holding register, occupied bit, and overflow detect), SHALL be instantiated NUM_VPE times.

Verification
REQ-036 In-order gather: lanes 0..7 each write 0x100+k on consecutive cycles with i_fifo_full=0 -> eight o_result_valid pulses carrying 0x100..0x107 in order; o_word_cnt=8.
REQ-037 Out-of-order arrival: lane 3 writes first, lane 0 two cycles later -> no emission until lane 0 arrives, then the order is 0,1,2,3 as lanes 1 and 2 fill; lane 3 is never emitted first.
REQ-038 Backpressure: i_fifo_full=1 for 5 cycles with all slots full -> no pulses, o_vpe_ready=0x00, o_busy=1; on release -> 8 pulses on 8 consecutive cycles.
REQ-039 Wrap: 24 words across three rounds -> rd_ptr returns to 0 with no idle cycle between rounds; o_word_cnt=24.
REQ-040 Overflow (macro defined): lane 2 writes twice while its slot is occupied -> o_overflow=1, the second value is never emitted; i_clear -> o_overflow=0, o_word_cnt=0.
REQ-041 Reset mid-run: assert rst_octo with 3 slots occupied -> no o_result_valid after release, o_vpe_ready=0xFF, o_result=0.
